// File: rtl/axi_rd_slv_sram.sv
// ============================================================================
// axi_rd_slv_sram : AXI read responder serving bursts from a 1-cycle SRAM.
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_rd_slv_sram #(
  parameter int AXI_DATA_WID  = 128,
  parameter int AXI_ADDR_WID  = 32,
  parameter int AXI_IDW       = 4,
  parameter int AXI_LENW      = 4,
  parameter int SRAM_AW       = 10,
  parameter int AR_FIFO_DEPTH = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    i_arvalid,
  input  logic [AXI_IDW-1:0]      i_arid,
  input  logic [AXI_ADDR_WID-1:0] i_araddr,
  input  logic [AXI_LENW-1:0]     i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  output logic                    o_arready,
  output logic                    o_rvalid,
  output logic [AXI_IDW-1:0]      o_rid,
  output logic [AXI_DATA_WID-1:0] o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  input  logic                    i_rready,
  output logic                    o_sram_cs,
  output logic [SRAM_AW-1:0]      o_sram_addr,
  input  logic [AXI_DATA_WID-1:0] i_sram_rdata,
  output logic                    o_busy,
  output logic [15:0]             o_ar_cnt
);

  localparam int PW = $clog2(AR_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FIFO_FULL = CW'(AR_FIFO_DEPTH);
  localparam int BYTE_OFS = 4;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // AR queue
  logic [AXI_IDW-1:0]  fifo_id_q   [AR_FIFO_DEPTH];
  logic [AXI_IDW-1:0]  fifo_id_d   [AR_FIFO_DEPTH];
  logic [SRAM_AW-1:0]  fifo_addr_q [AR_FIFO_DEPTH];
  logic [SRAM_AW-1:0]  fifo_addr_d [AR_FIFO_DEPTH];
  logic [AXI_LENW-1:0] fifo_len_q  [AR_FIFO_DEPTH];
  logic [AXI_LENW-1:0] fifo_len_d  [AR_FIFO_DEPTH];
  logic                fifo_err_q  [AR_FIFO_DEPTH];
  logic                fifo_err_d  [AR_FIFO_DEPTH];
  logic [PW-1:0]       fifo_wptr_q, fifo_wptr_d;
  logic [PW-1:0]       fifo_rptr_q, fifo_rptr_d;
  logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic                arready_q, arready_d;
  logic [15:0]         ar_cnt_q, ar_cnt_d;
  logic                ar_push, fifo_pop, fifo_nonempty;
  logic                ar_err;
  logic [AXI_ADDR_WID-1:0] ar_hi;
  logic                unused_addr_lo;

  // Burst engine
  state_t              state_q, state_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [AXI_LENW-1:0] cnt_q, cnt_d;
  logic [AXI_IDW-1:0]  id_q, id_d;
  logic                err_q, err_d;
  logic                issue, credit_ok;
  logic [2:0]          occ;

  // Beat sideband pipeline, aligned to the SRAM read latency
  logic                p_vld_q, p_vld_d;
  logic [AXI_IDW-1:0]  p_id_q, p_id_d;
  logic                p_last_q, p_last_d;
  logic                p_err_q, p_err_d;

  // R skid buffer
  logic [AXI_DATA_WID-1:0] buf_data_q [2];
  logic [AXI_DATA_WID-1:0] buf_data_d [2];
  logic [AXI_IDW-1:0]      buf_id_q   [2];
  logic [AXI_IDW-1:0]      buf_id_d   [2];
  logic                    buf_last_q [2];
  logic                    buf_last_d [2];
  logic [1:0]              buf_resp_q [2];
  logic [1:0]              buf_resp_d [2];
  logic                    buf_wptr_q, buf_wptr_d;
  logic                    buf_rptr_q, buf_rptr_d;
  logic [1:0]              buf_cnt_q, buf_cnt_d;
  logic                    buf_pop;

  assign ar_hi          = i_araddr >> (BYTE_OFS + SRAM_AW);
  assign ar_err         = (i_arburst != 2'b01) | (i_arsize != 3'd4) | (ar_hi != '0);
  assign unused_addr_lo = ^i_araddr[BYTE_OFS-1:0];
  assign fifo_nonempty  = (fifo_cnt_q != '0);

  always_comb begin
    fifo_id_d   = fifo_id_q;
    fifo_addr_d = fifo_addr_q;
    fifo_len_d  = fifo_len_q;
    fifo_err_d  = fifo_err_q;
    ar_push     = i_arvalid & arready_q;
    if (ar_push) begin
      fifo_id_d[fifo_wptr_q]   = i_arid;
      fifo_addr_d[fifo_wptr_q] = i_araddr[BYTE_OFS +: SRAM_AW];
      fifo_len_d[fifo_wptr_q]  = i_arlen;
      fifo_err_d[fifo_wptr_q]  = ar_err;
    end
    fifo_wptr_d = fifo_wptr_q + PW'(ar_push);
    fifo_rptr_d = fifo_rptr_q + PW'(fifo_pop);
    fifo_cnt_d  = fifo_cnt_q + CW'(ar_push) - CW'(fifo_pop);
    // Ready follows the registered occupancy, so a same-cycle pop cannot unblock a full queue
    arready_d   = (fifo_cnt_d != FIFO_FULL);
    ar_cnt_d    = ar_cnt_q + 16'(ar_push);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    err_d     = err_q;
    fifo_pop  = 1'b0;
    issue     = 1'b0;
    // Buffer occupancy after this cycle's pop plus the beat still in the SRAM pipe
    occ       = {1'b0, buf_cnt_q} + {2'b00, p_vld_q} - {2'b00, buf_pop};
    credit_ok = (occ < 3'd2);
    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty) begin
          fifo_pop = 1'b1;
          addr_d   = fifo_addr_q[fifo_rptr_q];
          cnt_d    = fifo_len_q[fifo_rptr_q];
          id_d     = fifo_id_q[fifo_rptr_q];
          err_d    = fifo_err_q[fifo_rptr_q];
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (credit_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + SRAM_AW'(1);
          cnt_d  = cnt_q - AXI_LENW'(1);
          if (cnt_q == '0) begin
            if (fifo_nonempty) begin
              fifo_pop = 1'b1;
              addr_d   = fifo_addr_q[fifo_rptr_q];
              cnt_d    = fifo_len_q[fifo_rptr_q];
              id_d     = fifo_id_q[fifo_rptr_q];
              err_d    = fifo_err_q[fifo_rptr_q];
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    p_vld_d  = issue;
    p_id_d   = id_q;
    p_last_d = (cnt_q == '0);
    p_err_d  = err_q;
  end

  assign o_sram_cs   = issue & ~err_q;
  assign o_sram_addr = addr_q;

  always_comb begin
    buf_data_d = buf_data_q;
    buf_id_d   = buf_id_q;
    buf_last_d = buf_last_q;
    buf_resp_d = buf_resp_q;
    buf_pop    = (buf_cnt_q != 2'd0) & i_rready;
    // Error beats take the same slot as real reads but carry zero data
    if (p_vld_q) begin
      buf_data_d[buf_wptr_q] = p_err_q ? '0 : i_sram_rdata;
      buf_id_d[buf_wptr_q]   = p_id_q;
      buf_last_d[buf_wptr_q] = p_last_q;
      buf_resp_d[buf_wptr_q] = p_err_q ? 2'b10 : 2'b00;
    end
    buf_wptr_d = buf_wptr_q ^ p_vld_q;
    buf_rptr_d = buf_rptr_q ^ buf_pop;
    buf_cnt_d  = buf_cnt_q + {1'b0, p_vld_q} - {1'b0, buf_pop};
  end

  assign o_rvalid  = (buf_cnt_q != 2'd0);
  assign o_rid     = buf_id_q[buf_rptr_q];
  assign o_rdata   = buf_data_q[buf_rptr_q];
  assign o_rresp   = buf_resp_q[buf_rptr_q];
  assign o_rlast   = buf_last_q[buf_rptr_q];
  assign o_arready = arready_q;
  assign o_ar_cnt  = ar_cnt_q;
  assign o_busy    = fifo_nonempty | (state_q == ST_RUN) | p_vld_q | (buf_cnt_q != 2'd0);

  always_ff @(posedge aclk) begin
    if (areset) begin
      fifo_id_q   <= '{default: '0};
      fifo_addr_q <= '{default: '0};
      fifo_len_q  <= '{default: '0};
      fifo_err_q  <= '{default: 1'b0};
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_cnt_q  <= '0;
      arready_q   <= 1'b0;
      ar_cnt_q    <= '0;
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      p_vld_q     <= 1'b0;
      p_id_q      <= '0;
      p_last_q    <= 1'b0;
      p_err_q     <= 1'b0;
      buf_data_q  <= '{default: '0};
      buf_id_q    <= '{default: '0};
      buf_last_q  <= '{default: 1'b0};
      buf_resp_q  <= '{default: '0};
      buf_wptr_q  <= 1'b0;
      buf_rptr_q  <= 1'b0;
      buf_cnt_q   <= 2'd0;
    end else begin
      fifo_id_q   <= fifo_id_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_len_q  <= fifo_len_d;
      fifo_err_q  <= fifo_err_d;
      fifo_wptr_q <= fifo_wptr_d;
      fifo_rptr_q <= fifo_rptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      arready_q   <= arready_d;
      ar_cnt_q    <= ar_cnt_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      err_q       <= err_d;
      p_vld_q     <= p_vld_d;
      p_id_q      <= p_id_d;
      p_last_q    <= p_last_d;
      p_err_q     <= p_err_d;
      buf_data_q  <= buf_data_d;
      buf_id_q    <= buf_id_d;
      buf_last_q  <= buf_last_d;
      buf_resp_q  <= buf_resp_d;
      buf_wptr_q  <= buf_wptr_d;
      buf_rptr_q  <= buf_rptr_d;
      buf_cnt_q   <= buf_cnt_d;
    end
  end

endmodule

`default_nettype wire
